alu_issue_stage: RTL and testbench

// - Decode/operand-fetch stage that sits directly upstream of the alu and drives its A, B and opcode_alu inputs.
// - Decodes RV32I R-type (0110011) and I-type ALU (0010011) instructions.
// - Holds the 32-entry register file, with x0 hardwired to zero.
// - Tracks writes that are still outstanding in a pending-register scoreboard.
// - Presents one registered operand bundle per accepted instruction using a valid/ready handshake.
// - The alu result returns through the write-back port.

---
 rtl/alu_issue_stage.sv | 159 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Decode/operand-fetch stage feeding the alu: RV32I R/I-type ALU decode, register
// file with write-back bypass, pending-write scoreboard and a registered valid/ready bundle.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   A,
    output logic [XLEN-1:0]   B,
    output logic [4:0]        opcode_alu,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_illegal,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data
);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] F7_ZERO  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    typedef enum logic [4:0] {
        ALU_NONE = 5'b00000,
        ALU_ADD  = 5'b00001,
        ALU_SUB  = 5'b00010,
        ALU_XOR  = 5'b00011,
        ALU_OR   = 5'b00100,
        ALU_AND  = 5'b00101,
        ALU_SLT  = 5'b01001
    } alu_op_e;

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [NREGS-1:0]  pending_q, pending_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    alu_op_e           op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              ill_q, ill_d;

    logic [6:0]        opc, f7;
    logic [2:0]        f3;
    logic [REG_AW-1:0] rd_f, rs1_f, rs2_f;
    logic              is_r, is_i, f3_ok, f7_ok, legal;
    alu_op_e           op_dec;
    logic [XLEN-1:0]   rs1_val, rs2_val, imm_val;
    logic              haz_rs1, haz_rs2, haz_rd, stall, accept;

    assign opc   = instr[6:0];
    assign rd_f  = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1_f = instr[19:15];
    assign rs2_f = instr[24:20];
    assign f7    = instr[31:25];
    assign is_r  = (opc == OPC_R);
    assign is_i  = (opc == OPC_I);

    always_comb begin
        op_dec = ALU_NONE;
        f3_ok  = 1'b1;
        unique case (f3)
            3'b000:  op_dec = (is_r && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b100:  op_dec = ALU_XOR;
            3'b110:  op_dec = ALU_OR;
            3'b111:  op_dec = ALU_AND;
            3'b010:  op_dec = ALU_SLT;
            default: f3_ok  = 1'b0;
        endcase
    end

    // funct7 only matters for R-type; the alternate encoding is valid only for SUB
    assign f7_ok = !is_r || (f7 == F7_ZERO) || (f7 == F7_ALT && f3 == 3'b000);
    assign legal = (is_r || is_i) && f3_ok && f7_ok;

    assign imm_val = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign rs1_val = (rs1_f == '0) ? '0 :
                     (wb_en && wb_rd == rs1_f) ? wb_data : regs_q[rs1_f];
    assign rs2_val = (rs2_f == '0) ? '0 :
                     (wb_en && wb_rd == rs2_f) ? wb_data : regs_q[rs2_f];

    assign haz_rs1 = pending_q[rs1_f] && !(wb_en && wb_rd == rs1_f);
    assign haz_rs2 = is_r && pending_q[rs2_f] && !(wb_en && wb_rd == rs2_f);
    assign haz_rd  = pending_q[rd_f] && !(wb_en && wb_rd == rd_f);
    assign stall   = legal && (haz_rs1 || haz_rs2 || haz_rd);

    assign in_ready = !rst && !stall && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rd_d    = rd_q;
        ill_d   = ill_q;
        if (accept) begin
            valid_d = 1'b1;
            if (legal) begin
                a_d   = rs1_val;
                b_d   = is_i ? imm_val : rs2_val;
                op_d  = op_dec;
                rd_d  = rd_f;
                ill_d = 1'b0;
            end else begin
                a_d   = '0;
                b_d   = '0;
                op_d  = ALU_NONE;
                rd_d  = '0;
                ill_d = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Set is applied after clear so a new claim on rd wins over a same-edge write-back
    always_comb begin
        pending_d = pending_q;
        if (wb_en && wb_rd != '0) pending_d[wb_rd] = 1'b0;
        if (accept && legal && rd_f != '0) pending_d[rd_f] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= ALU_NONE;
            rd_q      <= '0;
            ill_q     <= 1'b0;
            pending_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            ill_q     <= ill_d;
            pending_q <= pending_d;
            if (wb_en && wb_rd != '0) regs_q[wb_rd] <= wb_data;
        end
    end

    assign out_valid   = valid_q;
    assign A           = a_q;
    assign B           = b_q;
    assign opcode_alu  = op_q;
    assign out_rd      = rd_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios plus randomized traffic,
// checked against an instruction-level reference model of registers and pending writes.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, A, B, wb_data;
    logic [4:0]  opcode_alu, out_rd, wb_rd;
    logic        out_illegal, wb_en;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } bundle_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    bundle_t     sb[$];
    wb_t         wbq[$];
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_valid;
    bundle_t     m_cur;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .NREGS(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .opcode_alu(opcode_alu),
        .out_rd(out_rd), .out_illegal(out_illegal), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bundle_t model_issue(input logic [31:0] ins);
        bundle_t     nb;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        bit          is_r = (opc == 7'h33);
        bit          is_i = (opc == 7'h13);
        bit          ok   = is_r || is_i;
        nb = '{a: 0, b: 0, op: 0, rd: 0, ill: 1'b1};
        case (f3)
            3'd0: nb.op = (is_r && f7 == 7'h20) ? 5'd2 : 5'd1;
            3'd4: nb.op = 5'd3;
            3'd6: nb.op = 5'd4;
            3'd7: nb.op = 5'd5;
            3'd2: nb.op = 5'd9;
            default: ok = 0;
        endcase
        if (is_r && !(f7 == 0 || (f7 == 7'h20 && f3 == 0))) ok = 0;
        if (!ok) begin
            nb.op = 0;
            return nb;
        end
        nb.ill = 0;
        nb.rd  = ins[11:7];
        nb.a   = model_read(ins[19:15]);
        nb.b   = is_i ? {{20{ins[31]}}, ins[31:20]} : model_read(ins[24:20]);
        return nb;
    endfunction

    function automatic bit model_stall(input logic [31:0] ins);
        bundle_t    nb = model_issue(ins);
        logic [4:0] srcs[$];
        if (nb.ill) return 0;
        srcs.push_back(ins[19:15]);
        if (ins[6:0] == 7'h33) srcs.push_back(ins[24:20]);
        srcs.push_back(ins[11:7]);
        foreach (srcs[i])
            if (srcs[i] != 0 && m_pend[srcs[i]] && !(wb_en && wb_rd == srcs[i])) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] alu(input bundle_t x);
        case (x.op)
            5'd1: return x.a + x.b;
            5'd2: return x.a - x.b;
            5'd3: return x.a ^ x.b;
            5'd4: return x.a | x.b;
            5'd5: return x.a & x.b;
            5'd9: return ($signed(x.a) < $signed(x.b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_pend[i] = 0;
        end
        sb.delete();
        wbq.delete();
        m_valid = 0;
    endtask

    // One clock: drive at negedge, predict in_ready, commit the model at posedge
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd, input logic r, output bit acc);
        bundle_t nb;
        bit      exp_rdy, consume;
        @(negedge clk);
        rst = r; in_valid = v; instr = ins; out_ready = ordy;
        wb_en = we; wb_rd = wr; wb_data = wd;
        #1;
        exp_rdy = !r && !model_stall(ins) && (!m_valid || ordy);
        chk("in_ready", in_ready, exp_rdy);
        acc     = v && exp_rdy;
        consume = m_valid && ordy;
        nb      = model_issue(ins);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (consume && !m_cur.ill && m_cur.rd != 0)
                wbq.push_back('{rd: m_cur.rd, data: alu(m_cur)});
            if (we && wr != 0) begin
                m_regs[wr] = wd;
                m_pend[wr] = 0;
                for (int i = wbq.size() - 1; i >= 0; i--)
                    if (wbq[i].rd == wr) wbq.delete(i);
            end
            if (acc) begin
                sb.push_back(nb);
                if (!nb.ill && nb.rd != 0) m_pend[nb.rd] = 1;
                m_cur   = nb;
                m_valid = 1;
            end else if (consume) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic chk_zero();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_opcode", opcode_alu, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_illegal", out_illegal, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [2:0] f3s[5] = '{3'd0, 3'd4, 3'd6, 3'd7, 3'd2};
        logic [2:0] f3  = f3s[$urandom_range(0, 4)];
        logic [4:0] rd  = 5'($urandom_range(0, 7));
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        int unsigned k = $urandom_range(0, 15);
        if (k <= 8)
            return rtype((f3 == 0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
        if (k <= 13) return itype(12'($urandom), rs1, f3, rd);
        if (k == 14) return rtype(7'h00, 5'd0, 5'd0, 3'd1, 5'd0);
        return ($urandom_range(0, 1) == 1) ? {25'd0, 7'b0110111} : rtype(7'h01, 5'd0, 5'd0, 3'd0, 5'd0);
    endfunction

    // Monitor: compares the presented bundle against the oldest accepted expectation
    initial begin
        bundle_t e;
        forever begin
            @(negedge clk);
            #2;
            chk("out_valid", out_valid, sb.size() != 0);
            if (out_valid && sb.size() != 0) begin
                e = sb[0];
                chk("A", A, e.a);
                chk("B", B, e.b);
                chk("opcode_alu", opcode_alu, e.op);
                chk("out_rd", out_rd, e.rd);
                chk("out_illegal", out_illegal, e.ill);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          a;
        logic [31:0] pend_ins;
        bit          have_ins;
        logic        v, we;
        logic [4:0]  wr;
        logic [31:0] wd;

        rst = 1; in_valid = 0; instr = 0; out_ready = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        model_reset();
        step(0, 0, 1, 0, 0, 0, 1, a);
        step(0, 0, 1, 0, 0, 0, 1, a);
        chk_zero();

        // Immediate with sign extension
        step(0, 0, 1, 1, 5'd1, 32'd5, 0, a);
        step(1, itype(12'hFFD, 5'd1, 3'd0, 5'd2), 1, 0, 0, 0, 0, a);
        #1;
        chk("addi_A", A, 32'd5);
        chk("addi_B", B, 32'hFFFF_FFFD);
        chk("addi_op", opcode_alu, 5'b00001);
        chk("addi_rd", out_rd, 5'd2);

        // RAW stall released by the write-back, with bypass
        step(1, rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd3), 1, 0, 0, 0, 0, a);
        for (int i = 0; i < 3; i++)
            step(1, rtype(7'h20, 5'd1, 5'd3, 3'd0, 5'd4), 1, 0, 0, 0, 0, a);
        step(1, rtype(7'h20, 5'd1, 5'd3, 3'd0, 5'd4), 1, 1, 5'd3, 32'd77, 0, a);
        #1;
        chk("raw_A_bypass", A, 32'd77);
        chk("raw_B", B, 32'd5);
        chk("raw_op", opcode_alu, 5'b00010);

        // Back-pressure holds the bundle
        step(1, itype(12'd7, 5'd0, 3'd0, 5'd6), 1, 0, 0, 0, 0, a);
        for (int i = 0; i < 3; i++) begin
            step(1, itype(12'd5, 5'd0, 3'd4, 5'd7), 0, 0, 0, 0, 0, a);
            #1;
            chk("hold_B", B, 32'd7);
            chk("hold_rd", out_rd, 5'd6);
        end
        step(1, itype(12'd5, 5'd0, 3'd4, 5'd7), 1, 0, 0, 0, 0, a);
        #1;
        chk("bp_op", opcode_alu, 5'b00011);
        chk("bp_rd", out_rd, 5'd7);

        // x0 is never written and never pending
        step(0, 0, 1, 1, 5'd0, 32'd99, 0, a);
        step(1, rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd5), 1, 0, 0, 0, 0, a);
        #1;
        chk("x0_A", A, 0);
        chk("x0_B", B, 0);
        step(1, rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd0), 1, 0, 0, 0, 0, a);
        step(1, rtype(7'h00, 5'd0, 5'd0, 3'd6, 5'd0), 1, 0, 0, 0, 0, a);

        // Illegal SLL issues a zeroed bundle and claims no register
        step(1, rtype(7'h00, 5'd1, 5'd1, 3'd1, 5'd9), 1, 0, 0, 0, 0, a);
        #1;
        chk("ill_flag", out_illegal, 1);
        chk("ill_op", opcode_alu, 0);
        chk("ill_A", A, 0);
        chk("ill_rd", out_rd, 0);
        step(1, rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd9), 1, 0, 0, 0, 0, a);

        // Reset mid-stream with a bundle held and x10 pending
        step(1, rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd10), 1, 0, 0, 0, 0, a);
        step(0, 0, 0, 0, 0, 0, 0, a);
        step(0, 0, 0, 0, 0, 0, 1, a);
        chk_zero();
        step(1, rtype(7'h00, 5'd0, 5'd10, 3'd0, 5'd10), 1, 0, 0, 0, 0, a);

        // Randomized traffic
        have_ins = 0;
        pend_ins = 0;
        for (int c = 0; c < 600; c++) begin
            if (!have_ins) begin
                pend_ins = rand_instr();
                have_ins = 1;
            end
            v  = ($urandom_range(0, 3) != 0);
            we = 0; wr = 0; wd = 0;
            if (wbq.size() != 0 && $urandom_range(0, 1) == 1) begin
                we = 1; wr = wbq[0].rd; wd = wbq[0].data;
            end else if ($urandom_range(0, 7) == 0) begin
                we = 1; wr = 0; wd = $urandom;
            end
            step(v, pend_ins, ($urandom_range(0, 3) != 0), we, wr, wd, 0, a);
            if (a) have_ins = 0;
        end
        for (int c = 0; c < 4; c++) step(0, 0, 1, 0, 0, 0, 0, a);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
